// File: rtl/lane_register_bank.sv
// Eight-lane SIMT register file: each lane owns 64 x 32-bit registers, shared
// write/read addresses, per-lane enables, two combinational read ports.

module lane_register_bank_lane #(
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren_0,
    input  logic [ADDR_W-1:0] raddr_0,
    input  logic              ren_1,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign rdata_0 = ren_0 ? mem[raddr_0] : '0;
    assign rdata_1 = ren_1 ? mem[raddr_1] : '0;

endmodule

module lane_register_bank #(
    parameter int LANES    = 8,
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,     // active-high despite the name
    input  logic [LANES-1:0]  read_en_0,
    input  logic [LANES-1:0]  read_en_1,
    input  logic [ADDR_W-1:0] raddr_0,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [LANES-1:0]  write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic [DATA_W-1:0] wdata_3,
    input  logic [DATA_W-1:0] wdata_4,
    input  logic [DATA_W-1:0] wdata_5,
    input  logic [DATA_W-1:0] wdata_6,
    input  logic [DATA_W-1:0] wdata_7,
    output logic [DATA_W-1:0] rdata_0_0,
    output logic [DATA_W-1:0] rdata_0_1,
    output logic [DATA_W-1:0] rdata_0_2,
    output logic [DATA_W-1:0] rdata_0_3,
    output logic [DATA_W-1:0] rdata_0_4,
    output logic [DATA_W-1:0] rdata_0_5,
    output logic [DATA_W-1:0] rdata_0_6,
    output logic [DATA_W-1:0] rdata_0_7,
    output logic [DATA_W-1:0] rdata_1_0,
    output logic [DATA_W-1:0] rdata_1_1,
    output logic [DATA_W-1:0] rdata_1_2,
    output logic [DATA_W-1:0] rdata_1_3,
    output logic [DATA_W-1:0] rdata_1_4,
    output logic [DATA_W-1:0] rdata_1_5,
    output logic [DATA_W-1:0] rdata_1_6,
    output logic [DATA_W-1:0] rdata_1_7
);

    logic [LANES-1:0][DATA_W-1:0] wdata;
    logic [LANES-1:0][DATA_W-1:0] rdata_p0;
    logic [LANES-1:0][DATA_W-1:0] rdata_p1;

    // The flat per-lane port list maps onto packed lane vectors internally.
    assign wdata = {wdata_7, wdata_6, wdata_5, wdata_4,
                    wdata_3, wdata_2, wdata_1, wdata_0};

    assign {rdata_0_7, rdata_0_6, rdata_0_5, rdata_0_4,
            rdata_0_3, rdata_0_2, rdata_0_1, rdata_0_0} = rdata_p0;
    assign {rdata_1_7, rdata_1_6, rdata_1_5, rdata_1_4,
            rdata_1_3, rdata_1_2, rdata_1_1, rdata_1_0} = rdata_p1;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_register_bank_lane #(
            .NUM_REGS (NUM_REGS),
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst_n),
            .wen     (write_en[l]),
            .waddr   (waddr),
            .wdata   (wdata[l]),
            .ren_0   (read_en_0[l]),
            .raddr_0 (raddr_0),
            .ren_1   (read_en_1[l]),
            .raddr_1 (raddr_1),
            .rdata_0 (rdata_p0[l]),
            .rdata_1 (rdata_p1[l])
        );
    end

endmodule

// File: tb/tb_lane_register_bank.sv
// Scoreboard bench for lane_register_bank: expected read data is queued when a
// read is set up and popped against the combinational outputs.

module tb_lane_register_bank;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       read_en_0, read_en_1, write_en;
    logic [5:0]       raddr_0, raddr_1, waddr;
    logic [7:0][31:0] wd;
    logic [1:0][7:0][31:0] rd;

    logic [31:0] model [8][64];
    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lane_register_bank dut (
        .clk(clk), .rst_n(rst_n),
        .read_en_0(read_en_0), .read_en_1(read_en_1),
        .raddr_0(raddr_0), .raddr_1(raddr_1),
        .write_en(write_en), .waddr(waddr),
        .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
        .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
        .rdata_0_0(rd[0][0]), .rdata_0_1(rd[0][1]), .rdata_0_2(rd[0][2]), .rdata_0_3(rd[0][3]),
        .rdata_0_4(rd[0][4]), .rdata_0_5(rd[0][5]), .rdata_0_6(rd[0][6]), .rdata_0_7(rd[0][7]),
        .rdata_1_0(rd[1][0]), .rdata_1_1(rd[1][1]), .rdata_1_2(rd[1][2]), .rdata_1_3(rd[1][3]),
        .rdata_1_4(rd[1][4]), .rdata_1_5(rd[1][5]), .rdata_1_6(rd[1][6]), .rdata_1_7(rd[1][7])
    );

    task automatic clear_model();
        for (int l = 0; l < 8; l++)
            for (int a = 0; a < 64; a++) model[l][a] = 32'h0;
    endtask

    // One write cycle: drive at the falling edge, commit to the model at the rising edge.
    task automatic do_write(input logic [7:0] en, input logic [5:0] a, input logic [7:0][31:0] d);
        @(negedge clk);
        write_en = en; waddr = a; wd = d;
        @(posedge clk);
        for (int l = 0; l < 8; l++) if (en[l]) model[l][a] = d[l];
        #1 write_en = 8'h00;
    endtask

    task automatic drive_read(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [5:0] a0, input logic [5:0] a1);
        read_en_0 = e0; read_en_1 = e1; raddr_0 = a0; raddr_1 = a1;
        #1;
    endtask

    task automatic push_model(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [5:0] a0, input logic [5:0] a1);
        for (int l = 0; l < 8; l++) exp_q.push_back(e0[l] ? model[l][a0] : 32'h0);
        for (int l = 0; l < 8; l++) exp_q.push_back(e1[l] ? model[l][a1] : 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        logic [7:0][31:0] d;
        rst_n = 1'b1;
        clear_model();
        #2 drive_read(8'hFF, 8'hFF, 6'h00, 6'h3F);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h0);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL reset_zero p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
        // A clock edge while reset is held must not write.
        for (int l = 0; l < 8; l++) d[l] = 32'hDEAD_0000 + l;
        @(negedge clk); write_en = 8'hFF; waddr = 6'h00; wd = d;
        @(posedge clk); #1 write_en = 8'h00;
        drive_read(8'hFF, 8'hFF, 6'h00, 6'h00);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h0);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL reset_held_write p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
        // First edge after release accepts a write.
        @(negedge clk) rst_n = 1'b0;
        for (int l = 0; l < 8; l++) d[l] = 32'hC0DE_0000 + l;
        do_write(8'hFF, 6'h3F, d);
        drive_read(8'hFF, 8'hFF, 6'h3F, 6'h3F);
        push_model(8'hFF, 8'hFF, 6'h3F, 6'h3F);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL reset_release_write p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
        // Mid-operation reset clears immediately and drops the pending write.
        @(negedge clk); write_en = 8'hFF; waddr = 6'h01; wd = d;
        #1 rst_n = 1'b1;
        clear_model();
        drive_read(8'hFF, 8'hFF, 6'h3F, 6'h01);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h0);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL reset_async_clear p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h0);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL reset_abort_write p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
        @(negedge clk); write_en = 8'h00; rst_n = 1'b0;
    endtask

    task automatic test_all_lane();
        logic [31:0] e;
        logic [7:0][31:0] d;
        logic [7:0] e0 [3];
        logic [7:0] e1 [3];
        e0 = '{8'hFF, 8'h00, 8'hFF};
        e1 = '{8'h00, 8'hFF, 8'hFF};
        for (int l = 0; l < 8; l++) d[l] = 32'h1000_0000 + l;
        do_write(8'hFF, 6'h05, d);
        for (int r = 0; r < 3; r++) begin
            drive_read(e0[r], e1[r], 6'h05, 6'h05);
            for (int l = 0; l < 8; l++) exp_q.push_back(e0[r][l] ? 32'h1000_0000 + l : 32'h0);
            for (int l = 0; l < 8; l++) exp_q.push_back(e1[r][l] ? 32'h1000_0000 + l : 32'h0);
            for (int p = 0; p < 2; p++)
                for (int l = 0; l < 8; l++) begin
                    e = exp_q.pop_front(); total++;
                    if (rd[p][l] !== e) begin
                        bad++; $display("FAIL all_lane r%0d p%0d l%0d got=%h want=%h", r, p, l, rd[p][l], e);
                    end
                end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] e;
        logic [7:0][31:0] d;
        logic [7:0] e0 [3];
        logic [7:0] e1 [3];
        e0 = '{8'hFF, 8'h00, 8'hFF};
        e1 = '{8'h00, 8'hFF, 8'hFF};
        for (int a = 0; a < 64; a++)
            for (int n = 0; n < 100; n++) begin
                for (int l = 0; l < 8; l++) d[l] = $urandom();
                do_write(8'hFF, 6'(a), d);
                for (int r = 0; r < 3; r++) begin
                    drive_read(e0[r], e1[r], 6'(a), 6'(a));
                    push_model(e0[r], e1[r], 6'(a), 6'(a));
                    for (int p = 0; p < 2; p++)
                        for (int l = 0; l < 8; l++) begin
                            e = exp_q.pop_front(); total++;
                            if (rd[p][l] !== e) begin
                                bad++; $display("FAIL sweep a%0d r%0d p%0d l%0d got=%h want=%h", a, r, p, l, rd[p][l], e);
                            end
                        end
                end
            end
        // Every address must still hold its own last write (no aliasing).
        for (int a = 0; a < 64; a++) begin
            drive_read(8'hFF, 8'hFF, 6'(a), 6'(63 - a));
            push_model(8'hFF, 8'hFF, 6'(a), 6'(63 - a));
            for (int p = 0; p < 2; p++)
                for (int l = 0; l < 8; l++) begin
                    e = exp_q.pop_front(); total++;
                    if (rd[p][l] !== e) begin
                        bad++; $display("FAIL alias a%0d p%0d l%0d got=%h want=%h", a, p, l, rd[p][l], e);
                    end
                end
        end
    endtask

    task automatic test_lane_mask();
        logic [31:0] e;
        logic [7:0][31:0] d;
        for (int l = 0; l < 8; l++) d[l] = 32'hAAAA_AAAA;
        do_write(8'hFF, 6'h10, d);
        for (int l = 0; l < 8; l++) d[l] = 32'h5555_5555;
        do_write(8'h01, 6'h10, d);
        drive_read(8'hFF, 8'hFF, 6'h10, 6'h10);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) exp_q.push_back(l == 0 ? 32'h5555_5555 : 32'hAAAA_AAAA);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL lane_mask p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
    endtask

    task automatic test_read_gating();
        logic [31:0] e;
        drive_read(8'h0F, 8'hF0, 6'h10, 6'h10);
        for (int l = 0; l < 8; l++)
            exp_q.push_back(l >= 4 ? 32'h0 : (l == 0 ? 32'h5555_5555 : 32'hAAAA_AAAA));
        for (int l = 0; l < 8; l++)
            exp_q.push_back(l < 4 ? 32'h0 : 32'hAAAA_AAAA);
        for (int p = 0; p < 2; p++)
            for (int l = 0; l < 8; l++) begin
                e = exp_q.pop_front(); total++;
                if (rd[p][l] !== e) begin
                    bad++; $display("FAIL read_gating p%0d l%0d got=%h want=%h", p, l, rd[p][l], e);
                end
            end
    endtask

    task automatic test_read_during_write();
        logic [31:0] e;
        logic [7:0][31:0] d;
        for (int l = 0; l < 8; l++) d[l] = 32'h1111_1111;
        do_write(8'hFF, 6'h20, d);
        @(negedge clk);
        d[0] = 32'h2222_2222;
        write_en = 8'h01; waddr = 6'h20; wd = d;
        drive_read(8'h01, 8'h00, 6'h20, 6'h00);
        exp_q.push_back(32'h1111_1111);
        e = exp_q.pop_front(); total++;
        if (rd[0][0] !== e) begin
            bad++; $display("FAIL rdw_before got=%h want=%h", rd[0][0], e);
        end
        @(posedge clk);
        model[0][6'h20] = 32'h2222_2222;
        #1 exp_q.push_back(32'h2222_2222);
        e = exp_q.pop_front(); total++;
        if (rd[0][0] !== e) begin
            bad++; $display("FAIL rdw_after got=%h want=%h", rd[0][0], e);
        end
        write_en = 8'h00;
    endtask

    initial begin
        rst_n = 1'b1;
        read_en_0 = '0; read_en_1 = '0; raddr_0 = '0; raddr_1 = '0;
        write_en = '0; waddr = '0; wd = '0;
        test_reset();
        test_all_lane();
        test_sweep();
        test_lane_mask();
        test_read_gating();
        test_read_during_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_register_bank.md
Name: lane_register_bank

Overview:
- Multi-lane general-purpose register file: 8 lanes, each with a private array of 64 x 32-bit registers.
- One shared write address with per-lane write enables and per-lane write data.
- Two shared read addresses (ports 0 and 1) with per-lane read enables, giving two combinational read results per lane.
- Sits between the issue/operand-fetch stage and writeback of the SIMT execution datapath.

Parameters:
- LANES, 8, number of lanes; the port list below is fixed for 8.
- NUM_REGS, 64, registers per lane.
- DATA_W, 32, register width in bits.
- ADDR_W, 6, register address width (log2 NUM_REGS).

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-high reset; 1 = reset asserted, despite the name.
- read_en_0  in  8  bit L enables read port 0 for lane L.
- read_en_1  in  8  bit L enables read port 1 for lane L.
- raddr_0  in  6  read port 0 register address, shared by all lanes.
- raddr_1  in  6  read port 1 register address, shared by all lanes.
- write_en  in  8  bit L enables the write for lane L.
- waddr  in  6  write register address, shared by all lanes.
- wdata_0 .. wdata_7  in  32 each  write data for lanes 0..7.
- rdata_0_0 .. rdata_0_7  out  32 each  port 0 read data for lanes 0..7 (rdata_P_L = port P, lane L).
- rdata_1_0 .. rdata_1_7  out  32 each  port 1 read data for lanes 0..7.

Behaviour:
- Storage: mem[L][A], L = 0..7, A = 0..63, 32 bits each; lanes fully independent.
- Reset:
  - When rst_n = 1, all 512 registers clear to 0 immediately (asynchronous), independent of clk.
  - While reset is held, writes are ignored.
  - Release is synchronised by the consumer; a write is accepted on the first rising edge with rst_n = 0.
  - Reset asserted mid-operation aborts any pending write and clears everything.
- Write (synchronous): on a rising clk with rst_n = 0, for each L with write_en[L] = 1, mem[L][waddr] <= wdata_L.
  - Lanes with write_en[L] = 0 are unchanged.
  - write_en = 0 means no state change.
- Read (combinational, zero latency):
  - rdata_0_L = read_en_0[L] ? mem[L][raddr_0] : 0.
  - rdata_1_L = read_en_1[L] ? mem[L][raddr_1] : 0.
  - Outputs follow address, enable and array changes within the same cycle, with no clock involvement.
- Both ports may read the same or different addresses in the same cycle; they are fully independent.
- Read-during-write to the same address in the same cycle returns the old value; there is no write-to-read bypass. The new value is visible immediately after the rising edge.
- Output reset value: all rdata = 0 (array cleared, and zero whenever the enable is low).
- Addresses are full 6-bit range; no wrap or out-of-range case exists (0x3F is the last register).
- No handshake and no stall: every enabled access completes in its cycle.
- Register 0 is a normal writable register; it is not hardwired to zero.

Test Plan:
- Reset: assert rst_n = 1, then enable all reads at raddr_0 = raddr_1 = 0x00 and 0x3F -> every rdata = 0x00000000.
- All-lane write/read:
  - Setup: write_en = 0xFF, waddr = 0x05, wdata_L = 0x1000_0000 + L, one rising edge.
  - Read A: write_en = 0, read_en_0 = 0xFF, raddr_0 = 0x05 -> rdata_0_L = 0x1000_000L within the same cycle.
  - Read B: repeat on port 1 -> same values.
  - Read C: both ports simultaneously -> both correct.
- Sweep: for each address 0x00..0x3F, 100 random all-lane writes, each followed by the port-0, port-1 and dual-port reads in the preceding scenario -> every read matches the last written data; no aliasing between addresses.
- Lane mask:
  - Setup: write 0xAAAAAAAA to all lanes at 0x10, then write_en = 0x01 with wdata = 0x55555555.
  - Check: read 0x10 -> lane 0 = 0x55555555, lanes 1..7 = 0xAAAAAAAA.
- Read enable gating: read_en_0 = 0x0F, read_en_1 = 0xF0 at the populated address -> port 0 lanes 4..7 = 0 and port 1 lanes 0..3 = 0; the other lanes show stored data.
- Read-during-write: waddr = raddr_0 = 0x20 (old value 0x11111111), wdata_0 = 0x22222222, write_en = 0x01 -> rdata_0_0 = 0x11111111 before the edge and 0x22222222 after it.
